// File: rtl/ram_arbiter.sv
// Shares one RAM port between a data port and two instruction caches. Data has
// priority, bounded by a starvation counter. Instruction grants alternate round-robin.
module ram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    input  logic [1:0]       ramstate,
    input  logic [31:0]      ramload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore
);

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;

    ramstate_t w_rs;
    logic      w_d_req;
    logic      w_i_any;
    logic      w_access;

    assign w_rs     = ramstate_t'(ramstate);
    assign w_access = (w_rs == ACCESS);
    assign w_d_req  = dREN | dWEN;
    assign w_i_any  = |iREN;

    // Read data is broadcast; the wait lines tell each client when it is valid.
    assign dload    = ramload;
    assign iload[0] = ramload;
    assign iload[1] = ramload;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no
    // path through the case leaves a value unassigned and infers a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_starve_cnt_nxt = r_starve_cnt;
        ramREN           = 1'b0;
        ramWEN           = 1'b0;
        ramaddr          = '0;
        ramstore         = '0;
        dwait            = 1'b1;
        iwait            = 2'b11;

        unique case (r_state)
            IDLE: begin
                if (!w_i_any)
                    w_starve_cnt_nxt = '0;
                if (w_d_req && (!w_i_any || (r_starve_cnt < CNT_MAX))) begin
                    w_state_nxt = DGRANT;
                end else if (w_i_any) begin
                    w_state_nxt = IGRANT;
                    w_owner_nxt = (iREN == 2'b11) ? r_rr_ptr : iREN[1];
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!w_d_req) begin
                    // Requester withdrew: release the RAM without crediting anything.
                    w_state_nxt = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (w_access) begin
                        dwait       = 1'b0;
                        w_state_nxt = IDLE;
                        if (!w_i_any)
                            w_starve_cnt_nxt = '0;
                        else if (r_starve_cnt != CNT_MAX)
                            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
                    end
                end
            end

            IGRANT: begin
                ramaddr = iaddr[r_owner];
                if (!iREN[r_owner]) begin
                    w_state_nxt = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (w_access) begin
                        iwait[r_owner]   = 1'b0;
                        w_state_nxt      = IDLE;
                        w_rr_ptr_nxt     = ~r_owner;
                        w_starve_cnt_nxt = '0;
                    end
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int SM = 4;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             dREN = 1'b0, dWEN = 1'b0;
    logic [31:0]      daddr = '0, dstore = '0;
    logic             dwait;
    logic [31:0]      dload;
    logic [1:0]       iREN = 2'b00;
    logic [1:0][31:0] iaddr = '0;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       ramstate = RS_FREE;
    logic [31:0]      ramload = '0;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the RAM (0 none, 1 data, 2 icache), plus fairness state.
    int m_holder = 0;
    int m_owner  = 0;
    int m_rr     = 0;
    int m_starve = 0;

    // Outputs observed during the latest step, for directed checks.
    logic        obs_dwait, obs_ren, obs_wen;
    logic [1:0]  obs_iwait;
    logic [31:0] obs_addr, obs_store, obs_dload;

    ram_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_starve = 0;
    endtask

    // Expected outputs derived from who holds the RAM and the current inputs.
    task automatic compare_outputs();
        logic        e_ren, e_wen, e_dwait;
        logic [1:0]  e_iwait;
        logic [31:0] e_addr, e_store;
        bit          quit, done;
        e_ren = 0; e_wen = 0; e_dwait = 1; e_iwait = 2'b11; e_addr = 0; e_store = 0;
        if (m_holder == 1) begin
            quit = !(dREN || dWEN);
            done = !quit && ramstate == RS_ACCESS;
            e_wen   = !quit && dWEN;
            e_ren   = !quit && dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dwait = !done;
        end else if (m_holder == 2) begin
            quit = !iREN[m_owner];
            done = !quit && ramstate == RS_ACCESS;
            e_ren  = !quit;
            e_addr = iaddr[m_owner];
            if (done) e_iwait[m_owner] = 1'b0;
        end
        check("ramREN", 64'(ramREN), 64'(e_ren));
        check("ramWEN", 64'(ramWEN), 64'(e_wen));
        check("ramaddr", 64'(ramaddr), 64'(e_addr));
        check("ramstore", 64'(ramstore), 64'(e_store));
        check("dwait", 64'(dwait), 64'(e_dwait));
        check("iwait", 64'(iwait), 64'(e_iwait));
        check("dload", 64'(dload), 64'(ramload));
        check("iload", 64'(iload), {ramload, ramload});
        obs_dwait = dwait; obs_iwait = iwait; obs_ren = ramREN; obs_wen = ramWEN;
        obs_addr = ramaddr; obs_store = ramstore; obs_dload = dload;
    endtask

    // Advance the model by one clock using the inputs that were stable at the edge.
    task automatic model_update();
        int  irq;
        bit  dreq;
        irq  = int'(iREN);
        dreq = dREN || dWEN;
        if (m_holder == 0) begin
            if (irq == 0) m_starve = 0;
            if (dreq && (irq == 0 || m_starve < SM)) begin
                m_holder = 1;
            end else if (irq != 0) begin
                m_holder = 2;
                m_owner  = (irq == 3) ? m_rr : (irq == 2 ? 1 : 0);
            end
        end else if (m_holder == 1) begin
            if (!dreq) m_holder = 0;
            else if (ramstate == RS_ACCESS) begin
                m_holder = 0;
                m_starve = (irq == 0) ? 0 : ((m_starve + 1 > SM) ? SM : m_starve + 1);
            end
        end else begin
            if (!iREN[m_owner]) m_holder = 0;
            else if (ramstate == RS_ACCESS) begin
                m_holder = 0;
                m_rr     = 1 - m_owner;
                m_starve = 0;
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs compared 1 time unit later.
    task automatic step();
        #1;
        compare_outputs();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    // Reset asserted in the middle of a cycle; outputs must go idle right away.
    task automatic reset_mid();
        #1;
        compare_outputs();
        #1 RST = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic clear_inputs();
        dREN = 0; dWEN = 0; iREN = 2'b00; daddr = 0; dstore = 0;
        iaddr = '0; ramstate = RS_FREE; ramload = 0;
    endtask

    initial begin : main
        logic [9:0]  seq;
        int          n_done;
        logic [31:0] addrs [3];

        model_reset();
        @(negedge CLK);
        #1 compare_outputs();
        check("rst_dwait", 64'(dwait), 64'd1);
        check("rst_iwait", 64'(iwait), 64'd3);
        check("rst_ramREN", 64'(ramREN), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Data read with two BUSY cycles before ACCESS.
        dREN = 1; daddr = 32'h40; ramload = 32'hDEADBEEF;
        step();
        for (int k = 0; k < 3; k++) begin
            ramstate = (k < 2) ? RS_BUSY : RS_ACCESS;
            step();
            check("rd_ramREN", 64'(obs_ren), 64'd1);
            check("rd_ramaddr", 64'(obs_addr), 64'h40);
            check("rd_dwait", 64'(obs_dwait), (k == 2) ? 64'd0 : 64'd1);
        end
        check("rd_dload", 64'(obs_dload), 64'hDEADBEEF);
        dREN = 0;
        step();
        check("rd_idle_after", 64'(obs_ren), 64'd0);

        // Both icaches requesting: grants alternate starting with icache0.
        reset_mid();
        clear_inputs();
        iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramstate = RS_ACCESS;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_iwait != 2'b11 && n_done < 3) begin
                addrs[n_done] = obs_addr;
                n_done++;
            end
        end
        check("rr_count", 64'(n_done), 64'd3);
        check("rr_addr0", 64'(addrs[0]), 64'h100);
        check("rr_addr1", 64'(addrs[1]), 64'h200);
        check("rr_addr2", 64'(addrs[2]), 64'h100);

        // Data and icache1 both held: four data completions, then one instruction.
        reset_mid();
        clear_inputs();
        dREN = 1; iREN = 2'b10; ramstate = RS_ACCESS;
        seq = '0;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!obs_dwait)    begin seq = {seq[8:0], 1'b0}; n_done++; end
            if (!obs_iwait[1]) begin seq = {seq[8:0], 1'b1}; n_done++; end
        end
        check("starve_count", 64'(n_done), 64'd10);
        check("starve_seq", 64'(seq), 64'(10'b0000100001));

        // Write wins over read.
        reset_mid();
        clear_inputs();
        dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = RS_ACCESS;
        step();
        step();
        check("wr_ramWEN", 64'(obs_wen), 64'd1);
        check("wr_ramREN", 64'(obs_ren), 64'd0);
        check("wr_ramaddr", 64'(obs_addr), 64'h80);
        check("wr_ramstore", 64'(obs_store), 64'h12345678);

        // Icache0 withdraws during ACCESS: abort, pointer stays on icache0.
        reset_mid();
        clear_inputs();
        iREN = 2'b01; iaddr[0] = 32'h300; iaddr[1] = 32'h400; ramstate = RS_ACCESS;
        step();
        iREN = 2'b00;
        step();
        check("abort_iwait", 64'(obs_iwait), 64'd3);
        check("abort_ramREN", 64'(obs_ren), 64'd0);
        iREN = 2'b11;
        step();
        step();
        check("abort_rr_addr", 64'(obs_addr), 64'h300);
        check("abort_rr_iwait", 64'(obs_iwait), 64'b10);

        // Reset in the middle of a BUSY data grant.
        clear_inputs();
        dREN = 1; iREN = 2'b01; ramstate = RS_BUSY;
        step();
        step();
        check("pre_rst_ramREN", 64'(obs_ren), 64'd1);
        reset_mid();
        check("mid_rst_ramREN", 64'(obs_ren), 64'd0);
        check("mid_rst_dwait", 64'(obs_dwait), 64'd1);
        // Starvation count cleared: a fresh data request is granted ahead of icache0.
        ramstate = RS_ACCESS;
        step();
        step();
        check("post_rst_dgrant", 64'(obs_dwait), 64'd0);

        // Randomized traffic with sticky requests and occasional resets.
        clear_inputs();
        for (int k = 0; k < 4000; k++) begin
            int r;
            if ($urandom_range(9) < 3) dREN = 1'($urandom_range(1));
            if ($urandom_range(9) < 2) dWEN = 1'($urandom_range(1));
            if ($urandom_range(9) < 3) iREN = 2'($urandom_range(3));
            daddr    = $urandom;
            dstore   = $urandom;
            iaddr[0] = $urandom;
            iaddr[1] = $urandom;
            ramload  = $urandom;
            r = int'($urandom_range(99));
            ramstate = (r < 50) ? RS_ACCESS : (r < 75) ? RS_BUSY : (r < 92) ? RS_FREE : RS_ERROR;
            if ($urandom_range(199) == 0) reset_mid();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive completed data transactions allowed while an instruction request waits.
REQ-002 CLK  in  1  system clock, all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 dREN  in  1  data read request from coherence bus.
REQ-005 dWEN  in  1  data write request from coherence bus; wins over dREN when both set.
REQ-006 daddr  in  32  data word address.
REQ-007 dstore  in  32  data write word.
REQ-008 dwait  out  1  data stall; low for exactly the completing cycle.
REQ-009 dload  out  32  data read word.
REQ-010 iREN  in  2  instruction read request, bit n = icache n.
REQ-011 iaddr  in  2x32  instruction address per icache.
REQ-012 iwait  out  2  instruction stall per icache.
REQ-013 iload  out  2x32  instruction read word per icache.
REQ-014 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-015 ramload  in  32  RAM read word.
REQ-016 ramREN, ramWEN  out  1 each  RAM strobes.
REQ-017 ramaddr, ramstore  out  32 each  RAM address / write word.

Function
REQ-018 FSM states IDLE, DGRANT, IGRANT; registers owner (1 bit), rr_ptr (1 bit), starve_cnt (saturating at STARVE_MAX).
REQ-019 IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=1, iwait=2'b11.
REQ-020 IDLE next state: DGRANT if (dREN|dWEN) and (iREN==0 or starve_cnt<STARVE_MAX); else IGRANT if iREN!=0; else IDLE.
REQ-021 IGRANT entry: owner = the requesting icache if one requests; rr_ptr if both request.
REQ-022 DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore, all combinational from inputs.
REQ-023 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr[owner], ramstore=0; non-owner iwait held 1.
REQ-024 Completion is the cycle ramstate==ACCESS in a grant state: owner's wait=0 that cycle, next state IDLE.
REQ-025 FREE, BUSY, ERROR in a grant state: owner wait=1, strobes held, state held; ERROR never completes or aborts.
REQ-026 Abort: DGRANT with dREN=dWEN=0, or IGRANT with iREN[owner]=0 -> strobes 0 that cycle, next IDLE, no counter/pointer update.
REQ-027 Abort takes precedence over ACCESS in the same cycle.
REQ-028 Completed IGRANT: rr_ptr = ~owner, starve_cnt = 0.
REQ-029 Completed DGRANT: starve_cnt+1 (saturating) if iREN!=0 that cycle, else starve_cnt = 0.
REQ-030 IDLE with iREN==0: starve_cnt = 0.
REQ-031 dload = ramload; iload[0] = iload[1] = ramload, unconditionally.
REQ-032 One IDLE cycle between consecutive transactions; minimum 2 cycles per transaction.

Reset
REQ-033 RST=1 asynchronously forces IDLE, owner=0, rr_ptr=0, starve_cnt=0 and all REQ-019 output values.
REQ-034 RST mid-transaction drops ramREN/ramWEN in the same cycle; no completion reported.
REQ-035 First rising CLK with RST=0 evaluates REQ-020.

Verification
REQ-036 dREN=1, daddr=0x40, iREN=0; ramstate BUSY x2 then ACCESS, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles; dwait=0 and dload=0xDEADBEEF on cycle 3; IDLE next.
REQ-037 iREN=2'b11, iaddr0=0x100, iaddr1=0x200, ACCESS each grant -> grants alternate icache0, icache1, icache0; ramaddr 0x100, 0x200, 0x100.
REQ-038 dREN=1 and iREN[1]=1 held, every grant completes in 1 cycle, STARVE_MAX=4 -> 4 data completions, then one icache1 completion, then data resumes.
REQ-039 dWEN=1, dREN=1, daddr=0x80, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0x12345678.
REQ-040 IGRANT owner 0, iREN[0] dropped while ramstate=ACCESS -> iwait[0]=1, strobes 0, IDLE next, rr_ptr unchanged.
REQ-041 RST asserted mid-DGRANT with ramstate=BUSY -> ramREN=0, dwait=1 immediately; starve_cnt=0 and IDLE after release.
